// File: rtl/mem_wait_pkg.sv
// Shared definitions for the mem_wait_slave read target: state encoding,
// watchdog limit and default widths.
package mem_wait_pkg;

    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 4;
    localparam int WAIT_W_DEF = 3;
    localparam int TMO_LIMIT  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } state_t;

endpackage

// File: rtl/mem_wait_regfile.sv
// 2**AW x DW register file: one synchronous write port and one asynchronous
// read port, so a same-cycle write to the read address returns the old word.
module mem_wait_regfile #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_wait_slave.sv
// Read target for the go/ws/rd/ds controller: inserts wait_cyc wait states,
// returns a register-file word and advances its pointer on ds.
// Optional HOLD watchdog and sticky err port: define MEM_WAIT_SLAVE_TIMEOUT_EN.
module mem_wait_slave
    import mem_wait_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int WAIT_W = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd,
    input  logic              ds,
    input  logic [WAIT_W-1:0] wait_cyc,
    input  logic              load,
    input  logic [AW-1:0]     base_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              ws,
    output logic [DW-1:0]     rdata,
    output logic              rvalid,
    output logic [AW-1:0]     addr,
    output logic              busy,
    output state_t            dbg_state
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    // Handshake: rd is a level held by the controller for the whole request;
    // ws is our registered "keep waiting" reply; rvalid pulses once with the
    // captured word; ds is the controller's one-cycle "consumed" pulse that
    // retires the transaction and advances addr.

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              ws_d, rvalid_d;
    logic [DW-1:0]     rdata_d, rd_word;
    logic [AW-1:0]     addr_d;

    mem_wait_regfile #(.DW(DW), .AW(AW)) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr),
        .rd_data (rd_word)
    );

`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
    logic [3:0] wdog_q, wdog_d;
    logic       err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ws_d     = ws;
        rdata_d  = rdata;
        rvalid_d = 1'b0;
        addr_d   = addr;
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
        wdog_d   = 4'd0;
        err_d    = err;
`endif
        case (state_q)
            IDLE: begin
                if (rd) begin
                    if (wait_cyc != '0) begin
                        cnt_d   = wait_cyc - WAIT_W'(1);
                        ws_d    = 1'b1;
                        state_d = WAIT;
                    end else begin
                        ws_d     = 1'b0;
                        rdata_d  = rd_word;
                        rvalid_d = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            WAIT: begin
                if (!rd) begin
                    ws_d    = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    ws_d     = 1'b0;
                    rdata_d  = rd_word;
                    rvalid_d = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                ws_d = 1'b0;
                if (ds) begin
                    addr_d  = addr + AW'(1);
                    state_d = IDLE;
                end
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
                else if (wdog_q == 4'(TMO_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end
`endif
            end
            default: begin
                ws_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
        // A pointer load wins over the ds increment.
        if (load) addr_d = base_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ws      <= 1'b0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            addr    <= '0;
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
            wdog_q  <= 4'd0;
            err     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ws      <= ws_d;
            rdata   <= rdata_d;
            rvalid  <= rvalid_d;
            addr    <= addr_d;
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err     <= err_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_wait_slave.sv
// Self-checking bench for mem_wait_slave: directed wait/abort/wrap/reset
// cases plus a short randomized read loop, checked through a data scoreboard.
module tb_mem_wait_slave;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int WAIT_W = 3;

    logic              clk;
    logic              rst_n;
    logic              rd, ds, load, wr_en;
    logic [WAIT_W-1:0] wait_cyc;
    logic [AW-1:0]     base_addr, wr_addr;
    logic [DW-1:0]     wr_data;
    logic              ws, rvalid, busy;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     addr;
    logic [1:0]        dbg_state;
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
    logic              err;
`endif

    mem_wait_slave #(.DW(DW), .AW(AW), .WAIT_W(WAIT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd        (rd),
        .ds        (ds),
        .wait_cyc  (wait_cyc),
        .load      (load),
        .base_addr (base_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .ws        (ws),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .addr      (addr),
        .busy      (busy),
        .dbg_state (dbg_state)
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem_m [2**AW];
    logic [AW-1:0] addr_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // scoreboard: every rvalid pops one expected word
    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_q.size() == 0) check_eq("spurious_rvalid", 32'(rvalid), 32'd0);
            else check_eq("rdata", 32'(rdata), 32'(exp_q.pop_front()));
        end
    end

    // drivers: inputs change at negedge+1, well away from the rising edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        mem_m[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_read(input logic [WAIT_W-1:0] wc);
        wait_cyc = wc;
        rd = 1'b1;
        exp_q.push_back(mem_m[addr_m]);
    endtask

    task automatic finish_ds();
        rd = 1'b0; ds = 1'b1;
        tick();
        ds = 1'b0;
        addr_m = addr_m + AW'(1);
    endtask

    task automatic load_addr(input logic [AW-1:0] a);
        load = 1'b1; base_addr = a;
        tick();
        load = 1'b0;
        addr_m = a;
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; rd = 1'b0; ds = 1'b0; load = 1'b0; wr_en = 1'b0;
        wait_cyc = '0; base_addr = '0; wr_addr = '0; wr_data = '0;
        addr_m = '0;
        tick(); tick();
        check_eq("rst_ws", 32'(ws), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", 32'(rdata), 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        tick();

        write_word(4'h0, 8'hA5);
        write_word(4'h1, 8'h3C);
        write_word(4'hF, 8'h5A);

        // 1: three wait states, wait_cyc change after accept ignored
        start_read(3'd3);
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) wait_cyc = 3'd7;
            check_eq($sformatf("t1_ws_c%0d", i), 32'(ws), (i <= 3) ? 32'd1 : 32'd0);
            check_eq($sformatf("t1_busy_c%0d", i), 32'(busy), 32'd1);
        end
        check_eq("t1_state_hold", 32'(dbg_state), 32'd2);
        check_eq("t1_rvalid_seen", 32'(exp_q.size()), 32'd0);
        finish_ds();
        check_eq("t1_addr", 32'(addr), 32'(addr_m));
        check_eq("t1_idle", 32'(busy), 32'd0);

        // 2: zero-wait read
        start_read(3'd0);
        tick();
        rd = 1'b0;
        check_eq("t2_ws", 32'(ws), 32'd0);
        check_eq("t2_rvalid_seen", 32'(exp_q.size()), 32'd0);
        finish_ds();
        check_eq("t2_addr", 32'(addr), 32'(addr_m));

        // 3: wrap from 0xF, then load vs ds in the same cycle
        load_addr(4'hF);
        check_eq("t3_load", 32'(addr), 32'hF);
        start_read(3'd1);
        tick();
        check_eq("t3_ws", 32'(ws), 32'd1);
        tick();
        finish_ds();
        check_eq("t3_wrap", 32'(addr), 32'd0);
        start_read(3'd0);
        tick();
        rd = 1'b0; ds = 1'b1; load = 1'b1; base_addr = 4'h7;
        tick();
        ds = 1'b0; load = 1'b0; addr_m = 4'h7;
        check_eq("t3_load_over_ds", 32'(addr), 32'h7);
        check_eq("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: abort after two WAIT cycles
        start_read(3'd5);
        void'(exp_q.pop_back());
        tick(); tick();
        check_eq("t4_ws_before", 32'(ws), 32'd1);
        rd = 1'b0;
        tick();
        check_eq("t4_ws_fall", 32'(ws), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        check_eq("t4_addr", 32'(addr), 32'h7);
        check_eq("t4_rdata_kept", 32'(rdata), 32'hA5);

        // write collision: capture at addr 0 sees the old word, write lands
        load_addr(4'h0);
        start_read(3'd0);
        wr_en = 1'b1; wr_addr = 4'h0; wr_data = 8'h77;
        tick();
        wr_en = 1'b0; mem_m[0] = 8'h77;
        finish_ds();
        load_addr(4'h0);
        start_read(3'd0);
        tick();
        finish_ds();
        check_eq("coll_q_empty", 32'(exp_q.size()), 32'd0);

        // 5: asynchronous reset while in WAIT
        start_read(3'd4);
        void'(exp_q.pop_back());
        tick();
        check_eq("t5_ws_pre", 32'(ws), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_ws", 32'(ws), 32'd0);
        check_eq("t5_rvalid", 32'(rvalid), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_addr", 32'(addr), 32'd0);
        rd = 1'b0; addr_m = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // 6: withhold ds after a completed read
        start_read(3'd0);
        tick();
        rd = 1'b0;
        for (int i = 2; i <= 15; i++) tick();
        check_eq("t6_busy_c15", 32'(busy), 32'd1);
        tick();
`ifdef MEM_WAIT_SLAVE_TIMEOUT_EN
        check_eq("t6_err", 32'(err), 32'd1);
        check_eq("t6_idle", 32'(busy), 32'd0);
        check_eq("t6_addr", 32'(addr), 32'(addr_m));
`else
        check_eq("t6_hold", 32'(busy), 32'd1);
        check_eq("t6_state", 32'(dbg_state), 32'd2);
        finish_ds();
        check_eq("t6_addr", 32'(addr), 32'(addr_m));
`endif

        // randomized reads over a freshly filled register file
        for (int a = 0; a < 2**AW; a++) write_word(AW'(a), DW'($urandom_range(0, 255)));
        for (int n = 0; n < 10; n++) begin
            start_read(WAIT_W'($urandom_range(0, 7)));
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick();
                if (rvalid) got = 1'b1;
            end
            check_eq($sformatf("rnd_rvalid_%0d", n), 32'(got), 32'd1);
            finish_ds();
            check_eq($sformatf("rnd_addr_%0d", n), 32'(addr), 32'(addr_m));
        end
        check_eq("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_wait_slave.md
Name: mem_wait_slave

Overview:
- Read-side target that sits directly downstream of the go/ws/rd/ds read controller.
- Consumes the controller's rd strobe and generates the ws wait-state signal that steers its READ/DLY loop.
- After a programmable number of wait cycles it returns a word from a small internal register file.
- It advances its address pointer when the controller signals completion on ds.

Parameters:
- DW, 8, read/write data width.
- AW, 4, address width; register-file depth = 2**AW.
- WAIT_W, 3, width of the wait-cycle count input.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd  in  1  read strobe from the controller, level; held high through READ/DLY.
- ds  in  1  done strobe from the controller, one-cycle pulse.
- wait_cyc  in  WAIT_W  wait cycles to insert per read, sampled at transaction accept.
- load  in  1  synchronous load of the address pointer.
- base_addr  in  AW  value loaded on load.
- wr_en  in  1  register-file write enable.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- ws  out  1  wait-state request to the controller, registered.
- rdata  out  DW  read data, registered, held until the next read completes.
- rvalid  out  1  one-cycle pulse when rdata updates.
- addr  out  AW  current read pointer.
- busy  out  1  high in any state other than IDLE.
- err  out  1  timeout sticky flag; present only with the optional feature.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, ws=0, rvalid=0, rdata=0, addr=0, cnt=0, err=0. The register file is not reset.
- All outputs are registered. ws is valid in the cycle after rd is first seen, which is the controller's DLY cycle.
- States: IDLE, WAIT, HOLD.

IDLE:
- rd=1 with wait_cyc!=0: cnt<=wait_cyc-1; ws<=1; go to WAIT.
- rd=1 with wait_cyc==0: ws<=0; rdata<=mem[addr]; rvalid<=1; go to HOLD. Zero-wait read, one-cycle latency.

WAIT:
- Each clock with rd=1:
  - cnt!=0: cnt<=cnt-1; ws stays 1.
  - cnt==0: ws<=0; rdata<=mem[addr]; rvalid<=1; go to HOLD.
- Read latency from first rd cycle to rvalid is wait_cyc+1 clocks.
- rd=0 in WAIT (abort): ws<=0; go to IDLE. No rvalid, addr unchanged, rdata unchanged.

HOLD:
- ws=0 while awaiting ds.
- ds=1: addr<=addr+1, wrapping 2**AW-1 -> 0; go to IDLE.
- rd=1 without ds in HOLD is ignored. The controller will be in DONE, so no new transaction starts until IDLE.

Simultaneous and boundary rules:
- ds in IDLE or WAIT is ignored.
- load has priority over the ds increment in the same cycle: addr<=base_addr. load is legal in any state. A load during WAIT changes the word returned.
- wr_en same cycle, same address as the read capture: rdata gets the old word; the write lands.
- wait_cyc changes after accept have no effect on the current transaction.
- Reset mid-transaction returns to IDLE immediately, with ws and rvalid low the same instant.

Optional Feature:
- Macro: MEM_WAIT_SLAVE_TIMEOUT_EN.
- Defined:
  - A 4-bit watchdog runs in HOLD.
  - If ds is not seen within 15 clocks of entering HOLD: err<=1 (sticky until reset); addr is not incremented; go to IDLE.
  - The err port exists.
- Not defined:
  - HOLD waits indefinitely for ds.
  - No watchdog logic and no err port.

Decomposition:
- Shared package mem_wait_pkg holds:
  - the state encoding: IDLE=2'b00, WAIT=2'b01, HOLD=2'b10;
  - the timeout limit constant TMO_LIMIT=15;
  - default widths.
- One natural sub-module: mem_wait_regfile, 2**AW x DW, one synchronous write port and one asynchronous read port. The FSM and counter stay in the top.

Test Plan:
1. Write mem[0]=8'hA5, wait_cyc=3, rd high from cycle 0 -> ws=1 in cycles 1-3, ws=0 in cycle 4; rvalid pulses in cycle 4 with rdata=8'hA5; ds pulse -> addr=1.
2. wait_cyc=0, mem[1]=8'h3C, rd pulse -> ws stays 0; rvalid in cycle 1 with rdata=8'h3C.
3. load with base_addr=4'hF, read, ds -> addr wraps to 0. load and ds in the same cycle with base_addr=4'h7 -> addr=7.
4. wait_cyc=5, drop rd after 2 cycles -> ws falls the next cycle; no rvalid; addr unchanged; busy=0.
5. rst_n low while in WAIT with ws=1 -> ws, rvalid, busy and addr go to 0 immediately, without waiting for a clock edge.
6. With MEM_WAIT_SLAVE_TIMEOUT_EN, complete a read and withhold ds for 15 clocks -> err=1 and state=IDLE with addr unchanged; without the macro, the block stays in HOLD with busy=1.
